// File: rtl/if_fetch_queue_pkg.sv
// Shared defaults and FSM encoding for the instruction-fetch queue.
package if_fetch_queue_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned INST_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Fetch FSM encoding (2 bits)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, inst} entries with clear.
// Head outputs read as zero when the queue is empty.
module fetch_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  // Qualify push/pop and compute next pointers and occupancy; clear wins.
  always_comb begin
    pop_en   = pop && (count_q != '0);
    push_en  = push && ((count_q < CNT_W'(DEPTH)) || pop_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (push_en && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch unit: owns the fetch PC, keeps one memory read in
// flight, and buffers returned instructions with their PCs.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | no request outstanding
//  REQ     | request outstanding, response will be pushed
//  DROP    | request outstanding, response discarded (after redirect)
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              id_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc_o,
  output logic              if_stallreq
);

  localparam int unsigned       PTR_W      = $clog2(DEPTH);
  localparam int unsigned       CNT_W      = PTR_W + 1;
  localparam int unsigned       ENT_W      = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(PC_INC - ADDR_W'(1));

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              push;
  logic              pop;
  logic              clear;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic              slot_free;
  logic              head_valid;
  logic [ENT_W-1:0]  head_data;

  // Occupancy after this cycle's push/pop decides whether a new request
  // can be issued with a guaranteed free slot on return.
  always_comb begin
    pop         = head_valid && id_ready;
    count_after = count + CNT_W'(push) - CNT_W'(pop);
    slot_free   = (count_after < CNT_W'(DEPTH));
  end

  // State, fetch PC and registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next state and next fetch PC.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
    end else if ((state_q == ST_REQ) && mem_done) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (!redirect_valid && slot_free) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid) begin
          state_d = mem_done ? ST_IDLE : ST_DROP;
        end else if (mem_done) begin
          state_d = slot_free ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (mem_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue control and next registered request; the address is frozen
  // while a request is still outstanding, otherwise it follows fetch_pc.
  always_comb begin
    push       = (state_q == ST_REQ) && mem_done && !redirect_valid;
    clear      = redirect_valid;
    mem_req_d  = (state_d != ST_IDLE);
    mem_addr_d = fetch_pc_d;
    if (state_d == ST_DROP) begin
      mem_addr_d = mem_addr_q;
    end else if ((state_q == ST_REQ) && (state_d == ST_REQ) && !mem_done) begin
      mem_addr_d = mem_addr_q;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  ({fetch_pc_q, mem_rdata}),
    .pop        (pop),
    .clear      (clear),
    .count      (count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign inst_valid  = head_valid;
  assign pc_o        = head_data[ENT_W-1:INST_W];
  assign inst        = head_data[INST_W-1:0];
  assign if_stallreq = !head_valid;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a 32-bit/DEPTH=4 instance for the main
// scenarios and an 8-bit/DEPTH=2 instance for address and pointer wrap.
module tb_if_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc_o;
  logic        if_stallreq;

  logic        redirect_valid_w;
  logic [7:0]  redirect_pc_w;
  logic        mem_req_w;
  logic [7:0]  mem_addr_w;
  logic        mem_done_w;
  logic [31:0] mem_rdata_w;
  logic        id_ready_w;
  logic        inst_valid_w;
  logic [31:0] inst_w;
  logic [7:0]  pc_o_w;
  logic        if_stallreq_w;

  int n_cmp = 0;
  int n_bad = 0;

  int lat  = 0;
  bit hold = 1'b1;
  int wcnt = 0;
  bit hold_w = 1'b1;

  logic [31:0] sb[$];
  logic [7:0]  sbw[$];

  if_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .id_ready(id_ready), .inst_valid(inst_valid), .inst(inst),
    .pc_o(pc_o), .if_stallreq(if_stallreq)
  );

  if_fetch_queue #(.ADDR_W(8), .INST_W(32), .DEPTH(2), .RESET_PC(8'hF8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w),
    .mem_done(mem_done_w), .mem_rdata(mem_rdata_w),
    .id_ready(id_ready_w), .inst_valid(inst_valid_w), .inst(inst_w),
    .pc_o(pc_o_w), .if_stallreq(if_stallreq_w)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5EED_0000;
  endfunction

  // Memory model: mem_done after lat extra cycles of mem_req.
  always @(negedge clk) begin
    if (hold || !mem_req) begin
      mem_done = 1'b0;
      wcnt = 0;
    end else if (wcnt >= lat) begin
      mem_done  = 1'b1;
      mem_rdata = inst_of(mem_addr);
      wcnt = 0;
    end else begin
      mem_done = 1'b0;
      wcnt++;
    end
  end

  always @(negedge clk) begin
    if (hold_w || !mem_req_w) begin
      mem_done_w = 1'b0;
    end else begin
      mem_done_w  = 1'b1;
      mem_rdata_w = inst_of({24'h0, mem_addr_w});
    end
  end

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b1; hold_w = 1'b1; lat = 0;
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    id_ready_w = 1'b0; redirect_valid_w = 1'b0; redirect_pc_w = '0;
    mem_rdata = '0; mem_rdata_w = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    n_cmp++; if ({inst_valid, if_stallreq} !== 2'b01) begin n_bad++; $display("FAIL rst_valid_stall: got %b expected 01", {inst_valid, if_stallreq}); end
    n_cmp++; if ({inst, pc_o} !== 64'h0) begin n_bad++; $display("FAIL rst_head: got %h expected 0", {inst, pc_o}); end
    n_cmp++; if (mem_addr_w !== 8'hF8) begin n_bad++; $display("FAIL rst_w_addr: got %h expected f8", mem_addr_w); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL first_req: got %b/%h expected 1/0", mem_req, mem_addr); end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || inst_valid !== 1'b0 || if_stallreq !== 1'b1 || inst !== 32'h0 || pc_o !== 32'h0) begin
      n_bad++; $display("FAIL async_rst: got req=%b addr=%h v=%b st=%b inst=%h pc=%h expected 0/0/0/1/0/0",
                        mem_req, mem_addr, inst_valid, if_stallreq, inst, pc_o);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL rst_release_req: got %b/%h expected 1/0", mem_req, mem_addr); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp;
    int popped = 0;
    bit started = 1'b0;
    sb.delete();
    for (int i = 0; i < 10; i++) sb.push_back(32'(i * 4));
    id_ready = 1'b1; lat = 0; hold = 1'b0;
    for (int cyc = 0; cyc < 40 && popped < 10; cyc++) begin
      @(negedge clk); #1;
      if (inst_valid && id_ready) begin
        exp = sb.pop_front();
        n_cmp++;
        if (pc_o !== exp || inst !== inst_of(exp) || if_stallreq !== 1'b0) begin
          n_bad++; $display("FAIL stream_data: got pc=%h inst=%h st=%b expected pc=%h inst=%h st=0", pc_o, inst, if_stallreq, exp, inst_of(exp));
        end
        popped++; started = 1'b1;
      end else if (started) begin
        n_cmp++; n_bad++;
        $display("FAIL stream_gap: got inst_valid=%b expected 1", inst_valid);
      end
    end
    n_cmp++; if (popped != 10) begin n_bad++; $display("FAIL stream_count: got %0d expected 10", popped); end
    id_ready = 1'b0; hold = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int refills = 0;
    hold = 1'b1; id_ready = 1'b0; lat = 0;
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    pulse_reset();
    hold = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk); #1;
      if (mem_req && mem_done) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL bp_extra_req: got addr %h expected no request", mem_addr);
        end else begin
          exp = sb.pop_front();
          if (mem_addr !== exp) begin n_bad++; $display("FAIL bp_addr: got %h expected %h", mem_addr, exp); end
        end
      end
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL bp_req_count: got %0d missing expected 0", sb.size()); end
    n_cmp++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b1 || pc_o !== 32'h0) begin
      n_bad++; $display("FAIL bp_idle: got req=%b v=%b pc=%h expected 0/1/0", mem_req, inst_valid, pc_o);
    end
    id_ready = 1'b1;
    @(negedge clk); #1;
    id_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (mem_req && mem_done) begin
        n_cmp++;
        if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL bp_refill_addr: got %h expected 10", mem_addr); end
        refills++;
      end
      @(negedge clk); #1;
    end
    n_cmp++; if (refills != 1) begin n_bad++; $display("FAIL bp_refill_count: got %0d expected 1", refills); end
    n_cmp++; if (pc_o !== 32'h4 || mem_req !== 1'b0) begin n_bad++; $display("FAIL bp_head_after_pop: got pc=%h req=%b expected 4/0", pc_o, mem_req); end
    hold = 1'b1;
  endtask

  task automatic test_redirect_mid();
    logic [31:0] exp;
    int phase = 0;
    bit prev_req = 1'b0;
    hold = 1'b1; id_ready = 1'b1; lat = 3;
    sb.delete();
    sb.push_back(32'h0); sb.push_back(32'h4);
    sb.push_back(32'h100); sb.push_back(32'h104); sb.push_back(32'h108);
    pulse_reset();
    hold = 1'b0;
    for (int cyc = 0; cyc < 80 && sb.size() > 0; cyc++) begin
      @(negedge clk); #1;
      if (inst_valid && id_ready) begin
        exp = sb.pop_front();
        n_cmp++;
        if (pc_o !== exp || inst !== inst_of(exp)) begin
          n_bad++; $display("FAIL redir_data: got pc=%h inst=%h expected pc=%h inst=%h", pc_o, inst, exp, inst_of(exp));
        end
      end
      if (phase == 0 && mem_req && mem_addr == 32'h8 && !inst_valid) begin
        redirect_valid = 1'b1; redirect_pc = 32'h203; phase = 1;
      end else if (phase == 1) begin
        n_cmp++;
        if ({mem_req, mem_addr, inst_valid} !== {1'b1, 32'h8, 1'b0}) begin
          n_bad++; $display("FAIL drop_hold: got req=%b addr=%h v=%b expected 1/8/0", mem_req, mem_addr, inst_valid);
        end
        redirect_pc = 32'h103; phase = 2;
      end else if (phase == 2) begin
        redirect_valid = 1'b0; prev_req = mem_req; phase = 3;
      end else if (phase == 3) begin
        if (mem_req && !prev_req) begin
          n_cmp++;
          if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL redir_next_addr: got %h expected 100", mem_addr); end
          phase = 4;
        end
        prev_req = mem_req;
      end
    end
    n_cmp++;
    if (sb.size() != 0 || phase != 4) begin
      n_bad++; $display("FAIL redir_complete: got left=%0d phase=%0d expected 0/4", sb.size(), phase);
    end
    redirect_valid = 1'b0; id_ready = 1'b0; hold = 1'b1;
  endtask

  task automatic test_redirect_done();
    logic [31:0] exp;
    int phase = 0;
    hold = 1'b1; id_ready = 1'b1; lat = 1;
    sb.delete();
    sb.push_back(32'h0); sb.push_back(32'h40); sb.push_back(32'h44);
    pulse_reset();
    hold = 1'b0;
    for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
      @(negedge clk); #1;
      if (phase == 1) begin
        redirect_valid = 1'b0;
        n_cmp++;
        if ({mem_req, inst_valid} !== 2'b00 || mem_addr !== 32'h40) begin
          n_bad++; $display("FAIL coinc_after: got req=%b v=%b addr=%h expected 0/0/40", mem_req, inst_valid, mem_addr);
        end
        phase = 2;
      end
      if (inst_valid && id_ready) begin
        exp = sb.pop_front();
        n_cmp++;
        if (pc_o !== exp || inst !== inst_of(exp)) begin
          n_bad++; $display("FAIL coinc_data: got pc=%h inst=%h expected pc=%h inst=%h", pc_o, inst, exp, inst_of(exp));
        end
      end
      if (phase == 0 && mem_req && mem_done && mem_addr == 32'h4) begin
        redirect_valid = 1'b1; redirect_pc = 32'h40; phase = 1;
      end
    end
    n_cmp++;
    if (sb.size() != 0 || phase != 2) begin
      n_bad++; $display("FAIL coinc_complete: got left=%0d phase=%0d expected 0/2", sb.size(), phase);
    end
    redirect_valid = 1'b0; id_ready = 1'b0; hold = 1'b1;
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    hold = 1'b1; hold_w = 1'b1; id_ready_w = 1'b1;
    sbw.delete();
    for (int i = 0; i < 8; i++) sbw.push_back(8'(8'hF8 + 8'(i * 4)));
    pulse_reset();
    hold_w = 1'b0;
    for (int cyc = 0; cyc < 200 && sbw.size() > 0; cyc++) begin
      @(negedge clk); #1;
      if (inst_valid_w && id_ready_w) begin
        exp = sbw.pop_front();
        n_cmp++;
        if (pc_o_w !== exp || inst_w !== inst_of({24'h0, exp}) || if_stallreq_w !== 1'b0) begin
          n_bad++; $display("FAIL wrap_data: got pc=%h inst=%h expected pc=%h inst=%h", pc_o_w, inst_w, exp, inst_of({24'h0, exp}));
        end
      end
      id_ready_w = ($urandom_range(0, 3) != 0);
    end
    n_cmp++; if (sbw.size() != 0) begin n_bad++; $display("FAIL wrap_complete: got %0d left expected 0", sbw.size()); end
    hold_w = 1'b1; id_ready_w = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_mid();
    test_redirect_done();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
